// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - funct codes and muldiv FSM state encoding shared by the ALU files
package alu_pkg;

   localparam logic [5:0] FN_SRL   = 6'd2;
   localparam logic [5:0] FN_MFHI  = 6'd16;
   localparam logic [5:0] FN_MFLO  = 6'd18;
   localparam logic [5:0] FN_MULT  = 6'd24;
   localparam logic [5:0] FN_MULTU = 6'd25;
   localparam logic [5:0] FN_DIV   = 6'd26;
   localparam logic [5:0] FN_DIVU  = 6'd27;
   localparam logic [5:0] FN_ADD   = 6'd32;
   localparam logic [5:0] FN_SUB   = 6'd34;
   localparam logic [5:0] FN_AND   = 6'd36;
   localparam logic [5:0] FN_OR    = 6'd37;
   localparam logic [5:0] FN_SLT   = 6'd42;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_e;

endpackage

// File: rtl/muldiv_core.sv
// rtl/muldiv_core.sv - iterative unsigned shift-add multiplier / restoring divider
// One iteration per cycle over a shared 2*WIDTH accumulator: {HI part, LO part}.
module muldiv_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);

   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     dvsr_q, dvsr_d;
   logic                 div_q, div_d;
   logic [WIDTH:0]       add_sum;
   logic [WIDTH:0]       rem_try;
   logic [WIDTH:0]       rem_sub;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      dvsr_d  = dvsr_q;
      div_d   = div_q;
      add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, dvsr_q};
      rem_try = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      rem_sub = rem_try - {1'b0, dvsr_q};
      case (state_q)
         IDLE: begin
            if (start) begin
               acc_d   = {{WIDTH{1'b0}}, a};
               dvsr_d  = b;
               div_d   = op_div;
               cnt_d   = CW'(WIDTH);
               state_d = RUN;
            end
         end
         RUN: begin
            if (div_q) begin
               // rem_sub[WIDTH] is the borrow: set means the trial remainder was smaller than the divisor
               if (!rem_sub[WIDTH])
                  acc_d = {rem_sub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
               else
                  acc_d = {rem_try[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end else begin
               if (acc_q[0])
                  acc_d = {add_sum, acc_q[WIDTH-1:1]};
               else
                  acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1))
               state_d = FINISH;
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         dvsr_q  <= '0;
         div_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         dvsr_q  <= dvsr_d;
         div_q   <= div_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == FINISH);
   assign hi   = acc_q[2*WIDTH-1:WIDTH];
   assign lo   = acc_q[WIDTH-1:0];

endmodule

// File: rtl/alu_muldiv_param.sv
// rtl/alu_muldiv_param.sv - WIDTH-generic ALU with iterative muldiv and HI/LO pair
// Optional signed MULT/DIV enabled by defining SIGNED_MULDIV_EN.
module alu_muldiv_param
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   input  logic [5:0]       Signal,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Output
);

   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             core_start, core_div;
   logic [WIDTH-1:0] core_a, core_b;
   logic             core_busy, core_done;
   logic [WIDTH-1:0] core_hi, core_lo;
   logic             accept;

`ifdef SIGNED_MULDIV_EN
   logic             smul_q, smul_d;
   logic             sdiv_q, sdiv_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic [2*WIDTH-1:0] prod_neg;

   assign mag_a    = dataA[WIDTH-1] ? (~dataA + 1'b1) : dataA;
   assign mag_b    = dataB[WIDTH-1] ? (~dataB + 1'b1) : dataB;
   assign prod_neg = ~{core_hi, core_lo} + 1'b1;
`endif

   // Requests are only honoured while the core is neither iterating nor finishing.
   assign accept = start && !core_busy && !core_done;

   always_comb begin
      out_d      = out_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      core_start = 1'b0;
      core_div   = 1'b0;
      core_a     = dataA;
      core_b     = dataB;
`ifdef SIGNED_MULDIV_EN
      smul_d     = smul_q;
      sdiv_d     = sdiv_q;
      qneg_d     = qneg_q;
      rneg_d     = rneg_q;
`endif
      if (accept) begin
         case (Signal)
            FN_AND:  out_d = dataA & dataB;
            FN_OR:   out_d = dataA | dataB;
            FN_ADD:  out_d = dataA + dataB;
            FN_SUB:  out_d = dataA - dataB;
            FN_SLT:  out_d = {{(WIDTH-1){1'b0}}, ($signed(dataA) < $signed(dataB))};
            FN_SRL:  out_d = dataA >> dataB[SHAMT_W-1:0];
            FN_MFHI: out_d = hi_q;
            FN_MFLO: out_d = lo_q;
            FN_MULTU, FN_DIVU: begin
               core_start = 1'b1;
               core_div   = (Signal == FN_DIVU);
`ifdef SIGNED_MULDIV_EN
               smul_d = 1'b0;
               sdiv_d = 1'b0;
`endif
            end
`ifdef SIGNED_MULDIV_EN
            FN_MULT, FN_DIV: begin
               core_start = 1'b1;
               core_div   = (Signal == FN_DIV);
               core_a     = mag_a;
               core_b     = mag_b;
               smul_d     = (Signal == FN_MULT);
               sdiv_d     = (Signal == FN_DIV);
               qneg_d     = dataA[WIDTH-1] ^ dataB[WIDTH-1];
               rneg_d     = dataA[WIDTH-1];
            end
`endif
            default: out_d = '0;
         endcase
      end
      if (core_done) begin
         hi_d = core_hi;
         lo_d = core_lo;
`ifdef SIGNED_MULDIV_EN
         if (smul_q && qneg_q) begin
            hi_d = prod_neg[2*WIDTH-1:WIDTH];
            lo_d = prod_neg[WIDTH-1:0];
         end
         if (sdiv_q) begin
            if (qneg_q) lo_d = ~core_lo + 1'b1;
            if (rneg_q) hi_d = ~core_hi + 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
`ifdef SIGNED_MULDIV_EN
         smul_q <= 1'b0;
         sdiv_q <= 1'b0;
         qneg_q <= 1'b0;
         rneg_q <= 1'b0;
`endif
      end else begin
         out_q <= out_d;
         hi_q  <= hi_d;
         lo_q  <= lo_d;
`ifdef SIGNED_MULDIV_EN
         smul_q <= smul_d;
         sdiv_q <= sdiv_d;
         qneg_q <= qneg_d;
         rneg_q <= rneg_d;
`endif
      end
   end

   muldiv_core #(.WIDTH(WIDTH)) u_core (
      .clk    (clk),
      .reset  (reset),
      .start  (core_start),
      .op_div (core_div),
      .a      (core_a),
      .b      (core_b),
      .busy   (core_busy),
      .done   (core_done),
      .hi     (core_hi),
      .lo     (core_lo)
   );

   assign busy   = core_busy;
   assign done   = core_done;
   assign Output = out_q;

endmodule

// File: tb/tb_alu_muldiv_param.sv
// tb/tb_alu_muldiv_param.sv - directed scoreboard bench for alu_muldiv_param (WIDTH 32 and 8)
module tb_alu_muldiv_param;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] a32, b32, out32;
   logic [5:0]  sig32;
   logic        st32, busy32, done32;
   logic [7:0]  a8, b8, out8;
   logic [5:0]  sig8;
   logic        st8, busy8, done8;

   int          total = 0;
   int          bad = 0;
   logic [31:0] exp_q[$];
   string       tag_q[$];

   always #5 clk = ~clk;

   alu_muldiv_param #(.WIDTH(32)) dut32 (
      .clk(clk), .reset(reset), .dataA(a32), .dataB(b32), .Signal(sig32),
      .start(st32), .busy(busy32), .done(done32), .Output(out32)
   );

   alu_muldiv_param #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .dataA(a8), .dataB(b8), .Signal(sig8),
      .start(st8), .busy(busy8), .done(done8), .Output(out8)
   );

   function automatic logic [31:0] out_of(input bit w8);
      return w8 ? {24'b0, out8} : out32;
   endfunction

   function automatic logic busy_of(input bit w8);
      return w8 ? busy8 : busy32;
   endfunction

   function automatic logic done_of(input bit w8);
      return w8 ? done8 : done32;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit w8, input bit st, input logic [5:0] sig,
                        input logic [31:0] a, input logic [31:0] b);
      if (w8) begin
         st8 = st; sig8 = sig; a8 = a[7:0]; b8 = b[7:0];
      end else begin
         st32 = st; sig32 = sig; a32 = a; b32 = b;
      end
   endtask

   // Single-cycle op: expectation queued at drive time, checked after the accepting edge.
   task automatic issue(input bit w8, input string tag, input logic [5:0] sig,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      drive(w8, 1'b1, sig, a, b);
      tick();
      drive(w8, 1'b0, sig, a, b);
      check(tag_q.pop_front(), out_of(w8), exp_q.pop_front());
   endtask

   // Launch MULTU/DIVU; optionally inject an ADD start at cycle inject; check latency, busy, Output hold.
   task automatic muldiv(input bit w8, input string tag, input logic [5:0] sig,
                         input logic [31:0] a, input logic [31:0] b,
                         input int lat, input int inject);
      int          cyc;
      bit          busy_ok;
      logic [31:0] held;
      held    = out_of(w8);
      busy_ok = 1'b1;
      drive(w8, 1'b1, sig, a, b);
      tick();
      drive(w8, 1'b0, sig, a, b);
      cyc = 1;
      while (!done_of(w8) && cyc < 100) begin
         if (!busy_of(w8)) busy_ok = 1'b0;
         if (cyc == inject) drive(w8, 1'b1, 6'd32, 32'd1, 32'd1);
         tick();
         if (cyc == inject) drive(w8, 1'b0, 6'd32, 32'd1, 32'd1);
         cyc++;
      end
      check({tag, "_latency"}, cyc, lat);
      check({tag, "_busy"}, {31'b0, busy_ok}, 32'd1);
      check({tag, "_done_busy_low"}, {31'b0, busy_of(w8)}, 32'd0);
      check({tag, "_out_hold"}, out_of(w8), held);
      tick();
   endtask

   initial begin
      logic [63:0] prod;
      bit          saw_done;
      reset = 1'b1;
      drive(1'b0, 1'b0, 6'd0, 32'd0, 32'd0);
      drive(1'b1, 1'b0, 6'd0, 32'd0, 32'd0);
      tick();
      tick();
      reset = 1'b0;
      check("reset_out", out32, 32'd0);
      check("reset_busy", {31'b0, busy32}, 32'd0);
      check("reset_done", {31'b0, done32}, 32'd0);
      check("reset_out8", out_of(1'b1), 32'd0);

      issue(1'b0, "or", 6'd37, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF);
      issue(1'b0, "add_wrap", 6'd32, 32'hFFFF_FFFF, 32'd1, 32'd0);
      issue(1'b0, "sub", 6'd34, 32'd5, 32'd7, 32'hFFFF_FFFE);
      issue(1'b0, "slt_true", 6'd42, 32'hFFFF_FFFF, 32'd1, 32'd1);
      issue(1'b0, "slt_false", 6'd42, 32'd1, 32'hFFFF_FFFF, 32'd0);
      issue(1'b0, "srl31", 6'd2, 32'h8000_0000, 32'd31, 32'd1);
      issue(1'b0, "srl_mask", 6'd2, 32'hF000_0000, 32'h0000_0024, 32'h0F00_0000);
      issue(1'b0, "and", 6'd36, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
      issue(1'b0, "unknown", 6'd63, 32'd3, 32'd4, 32'd0);
      drive(1'b0, 1'b0, 6'd32, 32'd9, 32'd9);
      tick();
      check("idle_hold", out32, 32'd0);

      muldiv(1'b0, "multu_max", 6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0);
      issue(1'b0, "multu_hi", 6'd16, 32'd0, 32'd0, 32'hFFFF_FFFE);
      issue(1'b0, "multu_lo", 6'd18, 32'd0, 32'd0, 32'h0000_0001);

      muldiv(1'b0, "divu", 6'd27, 32'd100, 32'd7, 33, 0);
      issue(1'b0, "divu_lo", 6'd18, 32'd0, 32'd0, 32'd14);
      issue(1'b0, "divu_hi", 6'd16, 32'd0, 32'd0, 32'd2);
      muldiv(1'b0, "divu0", 6'd27, 32'd5, 32'd0, 33, 0);
      issue(1'b0, "divu0_lo", 6'd18, 32'd0, 32'd0, 32'hFFFF_FFFF);
      issue(1'b0, "divu0_hi", 6'd16, 32'd0, 32'd0, 32'd5);

      prod = 64'h1234_5678 * 64'h9ABC_DEF0;
      muldiv(1'b0, "multu_inj", 6'd25, 32'h1234_5678, 32'h9ABC_DEF0, 33, 5);
      issue(1'b0, "multu_inj_hi", 6'd16, 32'd0, 32'd0, prod[63:32]);
      issue(1'b0, "multu_inj_lo", 6'd18, 32'd0, 32'd0, prod[31:0]);

      drive(1'b0, 1'b1, 6'd25, 32'd7, 32'd9);
      tick();
      drive(1'b0, 1'b0, 6'd25, 32'd7, 32'd9);
      repeat (10) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_busy", {31'b0, busy32}, 32'd0);
      check("abort_out", out32, 32'd0);
      saw_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done32) saw_done = 1'b1;
         tick();
      end
      check("abort_no_done", {31'b0, saw_done}, 32'd0);
      issue(1'b0, "abort_hi", 6'd16, 32'd0, 32'd0, 32'd0);
      issue(1'b0, "abort_lo", 6'd18, 32'd0, 32'd0, 32'd0);

      muldiv(1'b1, "w8_multu", 6'd25, 32'd200, 32'd3, 9, 0);
      issue(1'b1, "w8_hi", 6'd16, 32'd0, 32'd0, 32'h02);
      issue(1'b1, "w8_lo", 6'd18, 32'd0, 32'd0, 32'h58);
      issue(1'b1, "w8_add", 6'd32, 32'd250, 32'd10, 32'd4);

`ifdef SIGNED_MULDIV_EN
      muldiv(1'b0, "mult", 6'd24, 32'hFFFF_FFFD, 32'd4, 33, 0);
      issue(1'b0, "mult_hi", 6'd16, 32'd0, 32'd0, 32'hFFFF_FFFF);
      issue(1'b0, "mult_lo", 6'd18, 32'd0, 32'd0, 32'hFFFF_FFF4);
      muldiv(1'b0, "div", 6'd26, 32'hFFFF_FFF9, 32'd2, 33, 0);
      issue(1'b0, "div_lo", 6'd18, 32'd0, 32'd0, 32'hFFFF_FFFD);
      issue(1'b0, "div_hi", 6'd16, 32'd0, 32'd0, 32'hFFFF_FFFF);
`else
      issue(1'b0, "pre24", 6'd32, 32'd3, 32'd4, 32'd7);
      issue(1'b0, "code24", 6'd24, 32'hFFFF_FFFD, 32'd4, 32'd0);
      check("code24_idle", {31'b0, busy32}, 32'd0);
      issue(1'b0, "pre26", 6'd32, 32'd3, 32'd4, 32'd7);
      issue(1'b0, "code26", 6'd26, 32'd7, 32'd2, 32'd0);
      issue(1'b0, "code24_lo", 6'd18, 32'd0, 32'd0, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
